// File: rtl/fifo_rd_adapter_if.sv
// Handshake bundle for the FIFO read-side adapter: FIFO read port plus downstream valid/ready stream.
// The adapter uses the master view; the FIFO and stream consumer together form the slave side.
interface fifo_rd_adapter_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic                  fifo_underflow;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  fifo_underflow,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output fifo_underflow,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_adapter.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream through a 2-entry skid buffer.
// Reads are only issued when a slot is guaranteed for the returning word, so nothing is lost or dropped.
module fifo_rd_adapter #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rd_adapter_if.master    bus,
    output logic [CNT_WIDTH-1:0] words_out,
    output logic                 err_underflow
);
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;
    logic                  inflight_reg;
    logic                  head_reg;
    logic                  tail_reg;
    logic [FIFO_WIDTH-1:0] entry_reg [2];
    logic [CNT_WIDTH-1:0]  words_reg;
    logic                  err_reg;

    logic                  pop;
    logic                  rd_en;
    logic [2:0]            level;

    // level is the occupancy the buffer will hold once this cycle's pop and
    // the in-flight capture have both landed; a new read needs a free slot there.
    always_comb begin
        pop      = (occ_reg != 2'd0) && bus.m_ready;
        level    = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
        rd_en    = !rst && !bus.fifo_empty && (level < 3'd2);
        occ_next = level[1:0];
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ_reg != 2'd0);
    assign bus.m_data     = entry_reg[head_reg];
    assign words_out      = words_reg;
    assign err_underflow  = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
            words_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= rd_en;
            if (pop) begin
                head_reg  <= ~head_reg;
                words_reg <= words_reg + 1'b1;
            end
            if (inflight_reg) begin
                tail_reg <= ~tail_reg;
            end
            if (bus.fifo_underflow) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Capture always targets the tail slot, so a simultaneous pop of the head never collides.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg[gi] <= '0;
                end else if (inflight_reg && (tail_reg == 1'(gi))) begin
                    entry_reg[gi] <= bus.fifo_dout;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (occ_reg <= 2'd2);
            assert (({1'b0, occ_reg} + {2'b00, inflight_reg}) <= 3'd2);
            assert (!(rd_en && bus.fifo_empty));
        end
    end
endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter: behavioural FIFO on the read port, logging monitor, and end-of-scenario checks.
module tb_fifo_rd_adapter;
    logic        clk;
    logic        rst;
    logic [3:0]  words_out;
    logic        err_underflow;

    fifo_rd_adapter_if #(.FIFO_WIDTH(16)) bus ();

    fifo_rd_adapter #(
        .FIFO_WIDTH(16),
        .CNT_WIDTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .words_out    (words_out),
        .err_underflow(err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus-side controls for the FIFO model
    logic        push_valid;
    logic [15:0] push_data;
    logic        flush;

    logic [15:0] fifo_q [$];
    int          viol_model;

    initial viol_model = 0;

    always @(posedge clk) begin
        if (flush) begin
            fifo_q.delete();
        end else begin
            if (bus.fifo_rd_en) begin
                if (fifo_q.size() > 0) begin
                    bus.fifo_dout <= fifo_q.pop_front();
                end else begin
                    bus.fifo_dout <= 16'hDEAD;
                    viol_model++;
                end
            end
            if (push_valid) fifo_q.push_back(push_data);
        end
        bus.fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: logs reads and handoffs, tracks words read but not yet handed off
    logic [15:0] recv [$];
    int          recv_cyc [$];
    int          rd_log [$];
    int          cyc, out_cnt;
    int          viol_empty, viol_out, viol_rst, viol_cnt;
    logic [3:0]  cnt_model;

    initial begin
        cyc = 0; out_cnt = 0; cnt_model = 4'd0;
        viol_empty = 0; viol_out = 0; viol_rst = 0; viol_cnt = 0;
    end

    always @(negedge clk) begin
        logic pop_s;
        cyc++;
        if (rst) begin
            out_cnt   = 0;
            cnt_model = 4'd0;
            if (bus.fifo_rd_en) viol_rst++;
        end else begin
            pop_s = bus.m_valid && bus.m_ready;
            if (bus.fifo_rd_en && bus.fifo_empty) viol_empty++;
            if (words_out !== cnt_model) viol_cnt++;
            if (bus.fifo_rd_en) rd_log.push_back(cyc);
            if (pop_s) begin
                recv.push_back(bus.m_data);
                recv_cyc.push_back(cyc);
                $display("[%0t] handoff #%0d data=%h words_out=%0d", $time, recv.size(), bus.m_data, words_out);
                cnt_model = cnt_model + 4'd1;
            end
            out_cnt = out_cnt + int'(bus.fifo_rd_en) - int'(pop_s);
            if (out_cnt > 2) viol_out++;
        end
    end

    // Checking
    int n_cmp, n_bad;
    logic [15:0] sent [$];
    int sb, rb, db;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        @(posedge clk); #2;
        push_valid = 1'b1;
        push_data  = w;
        sent.push_back(w);
    endtask

    task automatic push_stop();
        @(posedge clk); #2;
        push_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        push_valid = 1'b0;
        rst   = 1'b1;
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        rst   = 1'b0;
        sb = sent.size();
        rb = recv.size();
        db = rd_log.size();
    endtask

    task automatic wait_idle(input string tag);
        int idle;
        idle = 0;
        for (int i = 0; i < 200 && idle < 3; i++) begin
            @(negedge clk);
            if (!bus.m_valid && bus.fifo_empty && !bus.fifo_rd_en && !push_valid) idle++;
            else idle = 0;
        end
        if (idle < 3) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int ns, nr;
        ns = sent.size() - sb;
        nr = recv.size() - rb;
        chk({tag, "_count"}, nr, ns);
        for (int i = 0; i < ns && i < nr; i++) chk({tag, "_data"}, recv[rb + i], sent[sb + i]);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; flush = 1'b1;
        push_valid = 1'b0; push_data = 16'h0;
        bus.m_ready = 1'b0; bus.fifo_underflow = 1'b0;

        // Reset with 3 words loaded: no reads while rst is high
        repeat (2) @(posedge clk);
        #2 flush = 1'b0;
        sb = sent.size();
        push_word(16'h0111); push_word(16'h0222); push_word(16'h0333);
        push_stop();
        @(negedge clk);
        chk("rst_fifo_loaded", bus.fifo_empty, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_rd_en", bus.fifo_rd_en, 0);
        end
        @(posedge clk); #2 rst = 1'b0;
        rb = recv.size(); db = rd_log.size();
        @(negedge clk);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 16'h0000);
        chk("rst_words_out", words_out, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_first_rd", bus.fifo_rd_en, 1);
        bus.m_ready = 1'b1;
        wait_idle("rst_drain");
        compare_stream("rst_drain");

        // Streaming at full throughput
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        push_stop();
        wait_idle("stream");
        compare_stream("stream");
        chk("stream_rd_pulses", rd_log.size() - db, 8);
        if (recv.size() - rb >= 8 && rd_log.size() > db) begin
            chk("stream_latency", recv_cyc[rb] - rd_log[db], 2);
            for (int i = 1; i < 8; i++) chk("stream_back_to_back", recv_cyc[rb + i] - recv_cyc[rb + i - 1], 1);
        end else begin
            chk("stream_log_present", 32'd0, 32'd1);
        end
        chk("stream_words_out", words_out, 8);

        // Back-pressure: two reads only, head word held
        do_reset();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(16'(i));
        push_stop();
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", bus.m_valid, 1);
            chk("bp_hold", bus.m_data, 16'h0001);
        end
        chk("bp_rd_pulses", rd_log.size() - db, 2);
        @(posedge clk); #2 bus.m_ready = 1'b1;
        wait_idle("bp");
        compare_stream("bp");
        chk("bp_words_out", words_out, 5);

        // Alternating ready with random data
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_word(16'($urandom_range(0, 65535)));
            bus.m_ready = ~bus.m_ready;
        end
        push_stop();
        repeat (40) begin
            @(posedge clk); #2 bus.m_ready = ~bus.m_ready;
        end
        bus.m_ready = 1'b1;
        wait_idle("toggle");
        compare_stream("toggle");

        // Reset mid-stream, then a fresh word must be first out
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push_word(16'h1000 + 16'(i));
        do_reset();
        @(negedge clk);
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_m_data", bus.m_data, 16'h0000);
        chk("mid_rst_words_out", words_out, 0);
        push_word(16'hABCD);
        push_stop();
        wait_idle("mid_rst");
        chk("mid_rst_count", recv.size() - rb, 1);
        if (recv.size() > rb) chk("mid_rst_first", recv[rb], 16'hABCD);

        // Counter wrap: 17 handoffs on a 4-bit counter
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(16'h2000 + 16'(i));
        push_stop();
        wait_idle("wrap");
        compare_stream("wrap");
        chk("wrap_words_out", words_out, 1);

        // Sticky underflow error
        chk("err_before", err_underflow, 0);
        @(posedge clk); #2 bus.fifo_underflow = 1'b1;
        @(posedge clk); #2 bus.fifo_underflow = 1'b0;
        @(negedge clk);
        chk("err_set", err_underflow, 1);
        repeat (5) @(negedge clk);
        chk("err_sticky", err_underflow, 1);
        do_reset();
        @(negedge clk);
        chk("err_cleared", err_underflow, 0);

        // Invariants gathered by the monitor and FIFO model
        chk("rd_en_while_empty", viol_empty, 0);
        chk("occ_inflight_le2", viol_out, 0);
        chk("rd_en_in_rst", viol_rst, 0);
        chk("words_out_track", viol_cnt, 0);
        chk("fifo_read_when_empty", viol_model, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
